// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID pipeline register.
//
// Owns the PC and selects the next fetch address. The priority is EX redirect, then stall hold,
// then BTB prediction, then PC+4. It drives a synchronous instruction memory with a 1-cycle read
// latency and presents the fetched instruction to ID. The IF/ID register obeys the hazard-unit
// controls pc_en / if_id_en / if_id_flush / im_flush.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   pc_en_i                 0 = hold PC (load-use stall)
//   if_id_en_i              0 = hold IF/ID register
//   if_id_flush_i           load bubble into IF/ID
//   im_flush_i              current imem response is wrong-path
//   modify_pc_ex_i          EX redirect, target on pc_target_ex_i
//   btb_hit_taken_i         BTB predicts taken for pc_q, target on btb_target_i
//   imem_en_o, imem_addr_o  imem read request (address = next PC, combinational)
//   imem_rdata_i            imem data for the address issued last cycle
//   if_id_*_o               IF/ID register contents for ID
//
// Optional feature: define FETCH_PERF_CNT_EN to add saturating counters perf_fetched_o,
// perf_stall_o and perf_redirect_o.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_en_i,
    input  logic        if_id_en_i,
    input  logic        if_id_flush_i,
    input  logic        im_flush_i,
    input  logic        modify_pc_ex_i,
    input  logic [31:0] pc_target_ex_i,
    input  logic        btb_hit_taken_i,
    input  logic [31:0] btb_target_i,
    output logic        imem_en_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        if_id_pred_taken_o,
    output logic [31:0] if_id_pred_target_o,
    output logic        if_id_misaligned_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_redirect_o
`endif
);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        f_valid_q, f_valid_d;
    logic [31:0] next_pc;

    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic        id_pred_taken_q, id_pred_taken_d;
    logic [31:0] id_pred_target_q, id_pred_target_d;
    logic        id_misaligned_q, id_misaligned_d;

    logic run;
    assign run = (state_q == StRun);

    // Next-PC selection. A redirect beats a stall so a resolved branch is never lost.
    always_comb begin
        next_pc = pc_q + 32'd4;
        if (modify_pc_ex_i) begin
            next_pc = pc_target_ex_i;
        end else if (!pc_en_i) begin
            next_pc = pc_q;
        end else if (btb_hit_taken_i) begin
            next_pc = btb_target_i;
        end
    end

    // Fetch FSM and PC next-state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        f_valid_d   = f_valid_q;
        imem_en_o   = 1'b0;
        imem_addr_o = RESET_PC;
        if (!rst_i) begin
            imem_en_o = 1'b1;
            case (state_q)
                StBoot: begin
                    // Issue the first read; its data is captured in the first RUN cycle.
                    state_d   = StRun;
                    f_valid_d = 1'b1;
                end
                StRun: begin
                    imem_addr_o = next_pc;
                    pc_d        = next_pc;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StBoot;
            pc_q      <= RESET_PC;
            f_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            f_valid_q <= f_valid_d;
        end
    end

    // IF/ID next-state. BOOT has no instruction yet, so hazard inputs are ignored there.
    always_comb begin
        id_pc_d          = id_pc_q;
        id_instr_d       = id_instr_q;
        id_valid_d       = id_valid_q;
        id_pred_taken_d  = id_pred_taken_q;
        id_pred_target_d = id_pred_target_q;
        id_misaligned_d  = id_misaligned_q;
        if (rst_i || if_id_flush_i || !run) begin
            id_pc_d          = 32'd0;
            id_instr_d       = NOP_INSTR;
            id_valid_d       = 1'b0;
            id_pred_taken_d  = 1'b0;
            id_pred_target_d = 32'd0;
            id_misaligned_d  = 1'b0;
        end else if (if_id_en_i) begin
            id_pc_d          = pc_q;
            id_instr_d       = im_flush_i ? NOP_INSTR : imem_rdata_i;
            id_valid_d       = f_valid_q & ~im_flush_i;
            id_pred_taken_d  = btb_hit_taken_i;
            id_pred_target_d = btb_target_i;
            id_misaligned_d  = |pc_q[1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        id_pc_q          <= id_pc_d;
        id_instr_q       <= id_instr_d;
        id_valid_q       <= id_valid_d;
        id_pred_taken_q  <= id_pred_taken_d;
        id_pred_target_q <= id_pred_target_d;
        id_misaligned_q  <= id_misaligned_d;
    end

    assign if_id_pc_o          = id_pc_q;
    assign if_id_pc_plus4_o    = id_pc_q + 32'd4;
    assign if_id_instr_o       = id_instr_q;
    assign if_id_valid_o       = id_valid_q;
    assign if_id_pred_taken_o  = id_pred_taken_q;
    assign if_id_pred_target_o = id_pred_target_q;
    assign if_id_misaligned_o  = id_misaligned_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_stall_q, perf_redirect_q;
    logic        fetched_inc, stall_inc, redirect_inc;

    assign fetched_inc  = run & ~if_id_flush_i & if_id_en_i & f_valid_q & ~im_flush_i;
    assign stall_inc    = run & ~pc_en_i & ~modify_pc_ex_i;
    assign redirect_inc = run & modify_pc_ex_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetched_q  <= 32'd0;
            perf_stall_q    <= 32'd0;
            perf_redirect_q <= 32'd0;
        end else begin
            if (fetched_inc && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (stall_inc && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (redirect_inc && (perf_redirect_q != 32'hFFFF_FFFF)) begin
                perf_redirect_q <= perf_redirect_q + 32'd1;
            end
        end
    end

    assign perf_fetched_o  = perf_fetched_q;
    assign perf_stall_o    = perf_stall_q;
    assign perf_redirect_o = perf_redirect_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by randomized hazard traffic,
// all compared against a cycle-level reference model built from the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, pc_en, if_id_en, if_id_flush, im_flush, modify_pc_ex, btb_hit_taken;
    logic [31:0] pc_target_ex, btb_target;
    logic        imem_en;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr, if_id_pred_target;
    logic        if_id_valid, if_id_pred_taken, if_id_misaligned;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, perf_redirect;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .pc_en_i             (pc_en),
        .if_id_en_i          (if_id_en),
        .if_id_flush_i       (if_id_flush),
        .im_flush_i          (im_flush),
        .modify_pc_ex_i      (modify_pc_ex),
        .pc_target_ex_i      (pc_target_ex),
        .btb_hit_taken_i     (btb_hit_taken),
        .btb_target_i        (btb_target),
        .imem_en_o           (imem_en),
        .imem_addr_o         (imem_addr),
        .imem_rdata_i        (imem_rdata),
        .if_id_pc_o          (if_id_pc),
        .if_id_pc_plus4_o    (if_id_pc_plus4),
        .if_id_instr_o       (if_id_instr),
        .if_id_valid_o       (if_id_valid),
        .if_id_pred_taken_o  (if_id_pred_taken),
        .if_id_pred_target_o (if_id_pred_target),
        .if_id_misaligned_o  (if_id_misaligned)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o      (perf_fetched),
        .perf_stall_o        (perf_stall),
        .perf_redirect_o     (perf_redirect)
`endif
    );

    // Word-addressed instruction memory contents; low address bits are ignored.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_fn(imem_addr);
    end

    // Reference model state.
    bit          m_boot = 1'b1;
    bit          m_fv   = 1'b0;
    logic [31:0] m_pc   = RESET_PC;
    logic [31:0] m_id_pc = 32'd0, m_id_instr = NOP, m_id_ptgt = 32'd0;
    bit          m_id_valid = 1'b0, m_id_pt = 1'b0, m_id_mis = 1'b0;
    int unsigned m_fetched = 0, m_stall = 0, m_redirect = 0;
    logic [31:0] obs_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        m_id_pc = 32'd0; m_id_instr = NOP; m_id_valid = 1'b0;
        m_id_pt = 1'b0;  m_id_ptgt = 32'd0; m_id_mis = 1'b0;
    endtask

    // One clock: check the fetch request mid-cycle, advance the model, check IF/ID after the edge.
    task automatic cycle();
        logic [31:0] np;
        @(negedge clk);
        if (modify_pc_ex)       np = pc_target_ex;
        else if (!pc_en)        np = m_pc;
        else if (btb_hit_taken) np = btb_target;
        else                    np = m_pc + 32'd4;
        obs_addr = imem_addr;
        chk("imem_en", {31'd0, imem_en}, {31'd0, !rst});
        if (!rst) chk("imem_addr", imem_addr, m_boot ? RESET_PC : np);

        if (rst) begin
            m_boot = 1'b1; m_fv = 1'b0; m_pc = RESET_PC; bubble();
            m_fetched = 0; m_stall = 0; m_redirect = 0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_fv = 1'b1; bubble();
        end else begin
            if (!pc_en && !modify_pc_ex) m_stall++;
            if (modify_pc_ex) m_redirect++;
            if (if_id_flush) begin
                bubble();
            end else if (if_id_en) begin
                m_id_pc    = m_pc;
                m_id_instr = im_flush ? NOP : mem_fn(m_pc);
                m_id_valid = m_fv && !im_flush;
                m_id_pt    = btb_hit_taken;
                m_id_ptgt  = btb_target;
                m_id_mis   = (m_pc[1:0] != 2'b00);
                if (m_id_valid) m_fetched++;
            end
            m_pc = np;
        end

        @(posedge clk);
        #1;
        chk("if_id_pc", if_id_pc, m_id_pc);
        chk("if_id_pc_plus4", if_id_pc_plus4, m_id_pc + 32'd4);
        chk("if_id_instr", if_id_instr, m_id_instr);
        chk("if_id_flags", {29'd0, if_id_valid, if_id_pred_taken, if_id_misaligned},
            {29'd0, m_id_valid, m_id_pt, m_id_mis});
        chk("if_id_pred_target", if_id_pred_target, m_id_ptgt);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stall", perf_stall, m_stall);
        chk("perf_redirect", perf_redirect, m_redirect);
`endif
    endtask

    task automatic drive(input bit r, input bit pe, input bit ie, input bit fl, input bit imf,
                         input bit mod, input logic [31:0] tgt, input bit bh,
                         input logic [31:0] bt);
        rst = r; pc_en = pe; if_id_en = ie; if_id_flush = fl; im_flush = imf;
        modify_pc_ex = mod; pc_target_ex = tgt; btb_hit_taken = bh; btb_target = bt;
    endtask

    initial begin
        // Reset
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("reset_valid", {31'd0, if_id_valid}, 32'd0);
        chk("reset_instr", if_id_instr, NOP);

        // Sequential fetch out of reset
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t1_boot_addr", obs_addr, RESET_PC);
        cycle();
        chk("t1_first_pc", if_id_pc, 32'h0);
        chk("t1_first_valid", {31'd0, if_id_valid}, 32'd1);
        chk("t1_first_instr", if_id_instr, mem_fn(32'h0));
        repeat (3) cycle();
        chk("t1_pc_c", if_id_pc, 32'hC);

        // Load-use stall for three cycles at pc_q=0x10
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) begin
            cycle();
            chk("t2_hold_addr", obs_addr, 32'h10);
            chk("t2_hold_pc", if_id_pc, 32'hC);
        end
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t2_release_pc", if_id_pc, 32'h10);
        chk("t2_release_instr", if_id_instr, mem_fn(32'h10));

        // Redirect with flush
        drive(0, 1, 1, 1, 1, 1, 32'h200, 0, 0);
        cycle();
        chk("t3_bubble_valid", {31'd0, if_id_valid}, 32'd0);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t3_target_pc", if_id_pc, 32'h200);
        chk("t3_target_valid", {31'd0, if_id_valid}, 32'd1);

        // BTB prediction at pc_q=0x40
        drive(0, 1, 1, 1, 1, 1, 32'h40, 0, 0);
        cycle();
        drive(0, 1, 1, 0, 0, 0, 0, 1, 32'h80);
        cycle();
        chk("t4_btb_addr", obs_addr, 32'h80);
        chk("t4_pc", if_id_pc, 32'h40);
        chk("t4_pred", {31'd0, if_id_pred_taken}, 32'd1);
        chk("t4_pred_target", if_id_pred_target, 32'h80);

        // Redirect to a misaligned target during a stall
        drive(0, 0, 1, 1, 1, 1, 32'h102, 0, 0);
        cycle();
        chk("t5_addr", obs_addr, 32'h102);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t5_pc", if_id_pc, 32'h102);
        chk("t5_misaligned", {31'd0, if_id_misaligned}, 32'd1);

        // PC wrap at the top of the address space
        drive(0, 1, 1, 1, 1, 1, 32'hFFFF_FFF8, 0, 0);
        cycle();
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("wrap_addr", obs_addr, 32'h0);

        // Reset in the middle of a stall at pc_q=0x300
        drive(0, 1, 1, 1, 1, 1, 32'h300, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t6_valid", {31'd0, if_id_valid}, 32'd0);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t6_boot_addr", obs_addr, RESET_PC);
        cycle();
        chk("t6_refetch_pc", if_id_pc, RESET_PC);

        // Randomized hazard traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt, bt;
            bit          mod, pe;
            tgt = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            bt  = $urandom & 32'h0000_0FFC;
            mod = ($urandom_range(0, 9) == 0);
            pe  = ($urandom_range(0, 4) != 0);
            drive($urandom_range(0, 99) == 0, pe, pe || ($urandom_range(0, 3) == 0),
                  mod || ($urandom_range(0, 19) == 0), mod || ($urandom_range(0, 19) == 0),
                  mod, tgt, $urandom_range(0, 4) == 0, bt);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
